// File: rtl/m_psum_acc_pkg.sv
// Shared definitions for the partial-sum accumulator: FSM state type and
// the MAC output width helpers that size the row-0 and row-1.. inputs.
package m_psum_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } psum_state_e;

  function automatic int macLongWidth(input int dim3);
    return 14 + $clog2(dim3);
  endfunction

  function automatic int macShortWidth(input int dim3);
    return 10 + $clog2(dim3);
  endfunction

endpackage

// File: rtl/m_psum_acc_if.sv
// Partial-sum beat input and finished-tile output handshakes of m_psum_acc.
// slave = accumulator side, master = producer/consumer side.
interface m_psum_acc_if
  import m_psum_acc_pkg::*;
#(
  parameter int MMDimm1   = 8,
  parameter int MMDimm2   = 8,
  parameter int MMDimm3   = 16,
  parameter int ACC_WIDTH = 32,
  parameter int CNT_WIDTH = 16
) ();

  localparam int LW = macLongWidth(MMDimm3);
  localparam int SW = macShortWidth(MMDimm3);

  logic                                           in_valid;
  logic                                           in_ready;
  logic                                           in_first;
  logic                                           in_last;
  logic [MMDimm2-1:0][LW-1:0]                     cFirst;
  logic [MMDimm1-2:0][MMDimm2-1:0][SW-1:0]        cRest;
  logic                                           out_valid;
  logic                                           out_ready;
  logic [MMDimm1-1:0][MMDimm2-1:0][ACC_WIDTH-1:0] out_data;
  logic [CNT_WIDTH-1:0]                           out_count;
  logic                                           ovf;

  modport slave (
    input  in_valid, in_first, in_last, cFirst, cRest, out_ready,
    output in_ready, out_valid, out_data, out_count, ovf
  );

  modport master (
    output in_valid, in_first, in_last, cFirst, cRest, out_ready,
    input  in_ready, out_valid, out_data, out_count, ovf
  );

endinterface

// File: rtl/m_psum_acc_elem.sv
// One accumulator element: sign-extend, add, overflow detect.
// Define M_PSUM_ACC_SAT_EN to saturate on overflow instead of wrapping.
module m_psum_acc_elem #(
  parameter int IN_W      = 18,
  parameter int ACC_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic                 add_i,
  input  logic [IN_W-1:0]      din_i,
  output logic [ACC_WIDTH-1:0] acc_o,
  output logic                 ovf_o
);

  logic signed [ACC_WIDTH-1:0] acc_q, acc_d, din_ext;
  logic signed [ACC_WIDTH:0]   sum;
  logic                        sum_ovf;

`ifdef M_PSUM_ACC_SAT_EN
  function automatic logic signed [ACC_WIDTH-1:0] fit_acc(input logic signed [ACC_WIDTH:0] s);
    if (s[ACC_WIDTH] == s[ACC_WIDTH-1]) return s[ACC_WIDTH-1:0];
    return s[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
  endfunction
`else
  function automatic logic signed [ACC_WIDTH-1:0] fit_acc(input logic signed [ACC_WIDTH:0] s);
    return s[ACC_WIDTH-1:0];
  endfunction
`endif

  assign din_ext = ACC_WIDTH'($signed(din_i));
  // One guard bit: the top two sum bits disagree exactly on signed overflow.
  assign sum     = {acc_q[ACC_WIDTH-1], acc_q} + {din_ext[ACC_WIDTH-1], din_ext};
  assign sum_ovf = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
  assign ovf_o   = add_i & sum_ovf;
  assign acc_o   = acc_q;

  always_comb begin
    acc_d = acc_q;
    if (load_i)     acc_d = din_ext;
    else if (add_i) acc_d = fit_acc(sum);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

endmodule

// File: rtl/m_psum_acc.sv
// Tile partial-sum accumulator: sums chunk beats per element, then holds the
// tile until taken. Saturation selected by M_PSUM_ACC_SAT_EN (see elem).
module m_psum_acc
  import m_psum_acc_pkg::*;
#(
  parameter int MMDimm1   = 8,
  parameter int MMDimm2   = 8,
  parameter int MMDimm3   = 16,
  parameter int ACC_WIDTH = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  m_psum_acc_if.slave  bus
);

  localparam int LW = macLongWidth(MMDimm3);
  localparam int SW = macShortWidth(MMDimm3);

  psum_state_e                                    state_q, state_d;
  logic [CNT_WIDTH-1:0]                           count_q, count_d;
  logic                                           ovf_q, ovf_d;
  logic                                           ready, accept, load, add;
  logic [MMDimm1-1:0][MMDimm2-1:0][ACC_WIDTH-1:0] acc_w;
  logic [MMDimm1*MMDimm2-1:0]                     elem_ovf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, ACCUM: if (accept) state_d = bus.in_last ? HOLD : ACCUM;
      HOLD:        if (bus.out_ready) state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  // A beat in IDLE or flagged first restarts the tile; otherwise it adds.
  always_comb begin
    ready         = !reset && (state_q != HOLD);
    accept        = bus.in_valid & ready;
    load          = accept & ((state_q == IDLE) | bus.in_first);
    add           = accept & ~load;
    bus.in_ready  = ready;
    bus.out_valid = (state_q == HOLD);
    bus.out_data  = (state_q == HOLD) ? acc_w : '0;
    bus.out_count = (state_q == HOLD) ? count_q : '0;
    bus.ovf       = ovf_q;
  end

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (load) begin
      count_d = CNT_WIDTH'(1);
      ovf_d   = 1'b0;
    end else if (add) begin
      if (!(&count_q)) count_d = count_q + 1'b1;
      ovf_d = ovf_q | (|elem_ovf);
    end
  end

  for (genvar r = 0; r < MMDimm1; r++) begin : g_row
    for (genvar c = 0; c < MMDimm2; c++) begin : g_col
      if (r == 0) begin : g_long
        m_psum_acc_elem #(.IN_W(LW), .ACC_WIDTH(ACC_WIDTH)) u_elem (
          .clk    (clk),
          .reset  (reset),
          .load_i (load),
          .add_i  (add),
          .din_i  (bus.cFirst[c]),
          .acc_o  (acc_w[r][c]),
          .ovf_o  (elem_ovf[r*MMDimm2+c])
        );
      end else begin : g_short
        m_psum_acc_elem #(.IN_W(SW), .ACC_WIDTH(ACC_WIDTH)) u_elem (
          .clk    (clk),
          .reset  (reset),
          .load_i (load),
          .add_i  (add),
          .din_i  (bus.cRest[r-1][c]),
          .acc_o  (acc_w[r][c]),
          .ovf_o  (elem_ovf[r*MMDimm2+c])
        );
      end
    end
  end

endmodule

// File: doc/m_psum_acc.md
M_PSUM_ACC -- requirements
Module: m_psum_acc

Interface
REQ-001 SHALL have parameter MMDimm1, default 8: rows of C (row 0 long, rows 1..MMDimm1-1 short).
REQ-002 SHALL have parameter MMDimm2, default 8: columns of C.
REQ-003 SHALL have parameter MMDimm3, default 16: reduction depth per chunk; sets input widths.
REQ-004 SHALL have parameter ACC_WIDTH, default 32: accumulator width per element.
REQ-005 SHALL have parameter CNT_WIDTH, default 16: chunk-counter width.
REQ-006 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-007 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port in_valid, input, 1: partial-sum beat present.
REQ-009 SHALL have port in_ready, output, 1: block accepts beat this cycle.
REQ-010 SHALL have port in_first, input, 1: beat starts a new tile.
REQ-011 SHALL have port in_last, input, 1: beat ends the tile.
REQ-012 SHALL have port cFirst, input, MMDimm2 x (14+clog2(MMDimm3)): signed row-0 partial sums.
REQ-013 SHALL have port cRest, input, (MMDimm1-1) x MMDimm2 x (10+clog2(MMDimm3)): signed rows 1.. partial sums.
REQ-014 SHALL have port out_valid, output, 1: finished tile available.
REQ-015 SHALL have port out_ready, input, 1: consumer takes tile.
REQ-016 SHALL have port out_data, output, MMDimm1 x MMDimm2 x ACC_WIDTH: accumulated tile, signed.
REQ-017 SHALL have port out_count, output, CNT_WIDTH: chunks summed into out_data.
REQ-018 SHALL have port ovf, output, 1: sticky flag, an element exceeded ACC_WIDTH range in the current tile.

Function
REQ-019 SHALL implement states IDLE, ACCUM, HOLD.
REQ-020 SHALL drive in_ready=1 in IDLE and ACCUM, 0 in HOLD.
REQ-021 SHALL define accept as in_valid & in_ready.
REQ-022 SHALL sign-extend every input element to ACC_WIDTH before addition.
REQ-023 SHALL, on accept in IDLE or with in_first=1, load acc=sext(input), count=1, clear ovf.
REQ-024 SHALL, on accept in ACCUM with in_first=0, set acc+=sext(input), count+=1; count saturates at all-ones.
REQ-025 SHALL, on accept with in_last=1, enter HOLD next cycle (out_valid one cycle after last accept); otherwise enter or stay in ACCUM.
REQ-026 SHALL treat in_first=in_last=1 as a single-chunk tile: IDLE/ACCUM -> HOLD with acc=sext(input), count=1.
REQ-027 SHALL, in HOLD, assert out_valid and hold out_data, out_count and ovf stable until out_valid & out_ready.
REQ-028 SHALL go HOLD -> IDLE on out_ready; the next beat is accepted no earlier than the following cycle.
REQ-029 SHALL, when in_valid=0, leave acc and state unchanged (bubbles allowed mid-tile).
REQ-030 SHALL wrap acc modulo 2^ACC_WIDTH on overflow and set ovf, unless the saturation feature is enabled.

Reset
REQ-031 SHALL, on reset asserted at any time including mid-tile, force IDLE, acc=0, count=0, ovf=0, out_valid=0, in_ready=0 while reset is high.
REQ-032 SHALL drive out_data=0 and out_count=0 from reset until the first HOLD.

Configuration
REQ-033 SHALL saturate each element to the signed ACC_WIDTH min/max on overflow and set ovf when M_PSUM_ACC_SAT_EN is defined.
REQ-034 SHALL use the wrap behaviour of REQ-030 when M_PSUM_ACC_SAT_EN is not defined.

Structure
REQ-035 SHALL take the macShortWidth/macLongWidth width functions and the state enum type from the shared Common package.
REQ-036 SHALL use one sub-module, m_psum_acc_elem: one element's sext/add/saturate/ovf logic, instantiated MMDimm1 x MMDimm2 times.

Verification
REQ-037 SHALL check accumulation: 4 beats, all elements +3, first/last on beats 1/4 -> out_data all 12, out_count=4, out_valid one cycle after beat 4.
REQ-038 SHALL check single-beat tile: first=last=1, cFirst[0]=-5 -> out_data[0][0]=-5, count=1.
REQ-039 SHALL check backpressure: out_ready low 10 cycles in HOLD with in_valid high -> in_ready=0, out_data stable, nothing accepted.
REQ-040 SHALL check mid-tile reset: reset after 2 of 4 beats -> all outputs 0, IDLE; next tile sums from zero.
REQ-041 SHALL check overflow: ACC_WIDTH=16, add +20000 twice -> wrap -25536 with ovf=1; with M_PSUM_ACC_SAT_EN, 32767 with ovf=1.
REQ-042 SHALL check restart: in_first on beat 3 of a tile -> acc reloads, count=1.
